// File: rtl/rob.sv
// Reorder buffer: in-order allocate/rename at issue, out-of-order writeback,
// operand queries with same-cycle writeback bypass, in-order commit, and a
// flush on a mispredicted branch at the head.
module rob #(
   parameter int unsigned ROB_BIT  = 3,
   parameter int unsigned ROB_SIZE = 8
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                issue_valid,
   input  logic [4:0]          issue_rd,
   input  logic                issue_is_br,
   input  logic                issue_pred_taken,
   input  logic [31:0]         issue_alt_pc,
   output logic [ROB_BIT-1:0]  issue_tag,
   output logic                rob_full,
   output logic [4:0]          set_dep_id,
   output logic [ROB_BIT-1:0]  set_dep_Q,
   input  logic                wb_valid,
   input  logic [ROB_BIT-1:0]  wb_tag,
   input  logic [31:0]         wb_val,
   input  logic                wb_taken,
   input  logic [ROB_BIT-1:0]  get_rob_id_1,
   output logic                rob_avail_1,
   output logic [31:0]         rob_val_1,
   input  logic [ROB_BIT-1:0]  get_rob_id_2,
   output logic                rob_avail_2,
   output logic [31:0]         rob_val_2,
   output logic [4:0]          set_id,
   output logic [31:0]         set_val,
   output logic                rob_clear,
   output logic [31:0]         redirect_pc
);

   localparam int unsigned CNT_W = ROB_BIT + 1;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [4:0]  rd;
      logic        is_br;
      logic        pred_taken;
      logic        taken;
      logic [31:0] alt_pc;
      logic [31:0] val;
   } entry_t;

   entry_t             ent_q [ROB_SIZE];
   entry_t             ent_d [ROB_SIZE];
   logic [ROB_BIT-1:0] head_q, head_d;
   logic [ROB_BIT-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   entry_t head_ent_c;
   logic   full_c;
   logic   commit_c;
   logic   flush_c;
   logic   issue_ok_c;
   logic   wb_hit1_c;
   logic   wb_hit2_c;

   // Control decode: everything is gated by reset so outputs read 0 in reset.
   assign head_ent_c = ent_q[head_q];
   assign full_c     = (count_q == CNT_W'(ROB_SIZE));
   assign commit_c   = rst_in && rdy_in && head_ent_c.busy && head_ent_c.ready;
   assign flush_c    = commit_c && head_ent_c.is_br &&
                       (head_ent_c.taken != head_ent_c.pred_taken);
   assign issue_ok_c = rst_in && rdy_in && issue_valid && !full_c && !flush_c;

   // Allocation / rename outputs.
   assign rob_full   = full_c;
   assign issue_tag  = tail_q;
   assign set_dep_id = issue_ok_c ? issue_rd : 5'd0;
   assign set_dep_Q  = issue_ok_c ? tail_q : '0;

   // Commit outputs; branches never write the register file.
   assign set_id      = (commit_c && !head_ent_c.is_br) ? head_ent_c.rd  : 5'd0;
   assign set_val     = (commit_c && !head_ent_c.is_br) ? head_ent_c.val : 32'd0;
   assign rob_clear   = flush_c;
   assign redirect_pc = flush_c ? head_ent_c.alt_pc : 32'd0;

   // Operand queries with same-cycle writeback bypass.
   assign wb_hit1_c   = rst_in && wb_valid && (wb_tag == get_rob_id_1);
   assign wb_hit2_c   = rst_in && wb_valid && (wb_tag == get_rob_id_2);
   assign rob_avail_1 = wb_hit1_c ||
                        (rst_in && ent_q[get_rob_id_1].busy && ent_q[get_rob_id_1].ready);
   assign rob_avail_2 = wb_hit2_c ||
                        (rst_in && ent_q[get_rob_id_2].busy && ent_q[get_rob_id_2].ready);
   assign rob_val_1   = !rst_in   ? 32'd0  :
                        wb_hit1_c ? wb_val : ent_q[get_rob_id_1].val;
   assign rob_val_2   = !rst_in   ? 32'd0  :
                        wb_hit2_c ? wb_val : ent_q[get_rob_id_2].val;

   // Next-state: flush wins; otherwise writeback, commit pop and issue push.
   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy_in) begin
         if (flush_c) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
               ent_d[ROB_BIT'(i)].busy = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (wb_valid && ent_q[wb_tag].busy) begin
               ent_d[wb_tag].ready = 1'b1;
               ent_d[wb_tag].val   = wb_val;
               ent_d[wb_tag].taken = wb_taken;
            end
            if (commit_c) begin
               ent_d[head_q].busy = 1'b0;
               head_d             = head_q + ROB_BIT'(1);
            end
            if (issue_ok_c) begin
               ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: issue_rd,
                                 is_br: issue_is_br, pred_taken: issue_pred_taken,
                                 taken: 1'b0, alt_pc: issue_alt_pc, val: 32'd0};
               tail_d        = tail_q + ROB_BIT'(1);
            end
            count_d = count_q + CNT_W'(issue_ok_c) - CNT_W'(commit_c);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            ent_q[ROB_BIT'(i)] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_rob;

   localparam int ROB_BIT  = 3;
   localparam int ROB_SIZE = 8;

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic               rdy_in;
   logic               issue_valid;
   logic [4:0]         issue_rd;
   logic               issue_is_br;
   logic               issue_pred_taken;
   logic [31:0]        issue_alt_pc;
   logic [ROB_BIT-1:0] issue_tag;
   logic               rob_full;
   logic [4:0]         set_dep_id;
   logic [ROB_BIT-1:0] set_dep_Q;
   logic               wb_valid;
   logic [ROB_BIT-1:0] wb_tag;
   logic [31:0]        wb_val;
   logic               wb_taken;
   logic [ROB_BIT-1:0] get_rob_id_1;
   logic               rob_avail_1;
   logic [31:0]        rob_val_1;
   logic [ROB_BIT-1:0] get_rob_id_2;
   logic               rob_avail_2;
   logic [31:0]        rob_val_2;
   logic [4:0]         set_id;
   logic [31:0]        set_val;
   logic               rob_clear;
   logic [31:0]        redirect_pc;

   int n_cmp = 0;
   int n_bad = 0;

   rob #(.ROB_BIT(ROB_BIT), .ROB_SIZE(ROB_SIZE)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
      .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
      .issue_tag(issue_tag), .rob_full(rob_full),
      .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_taken(wb_taken),
      .get_rob_id_1(get_rob_id_1), .rob_avail_1(rob_avail_1), .rob_val_1(rob_val_1),
      .get_rob_id_2(get_rob_id_2), .rob_avail_2(rob_avail_2), .rob_val_2(rob_val_2),
      .set_id(set_id), .set_val(set_val), .rob_clear(rob_clear), .redirect_pc(redirect_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: program-order queue of live entries
   typedef struct {
      int          tag;
      logic [4:0]  rd;
      bit          is_br;
      bit          pred;
      bit          ready;
      bit          taken;
      logic [31:0] alt;
      logic [31:0] val;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_tail = 0;

   function automatic void qmodel(input int id, output bit av, output logic [31:0] v);
      av = 1'b0;
      v  = 32'd0;
      if (wb_valid && int'(wb_tag) == id) begin
         av = 1'b1;
         v  = wb_val;
      end else begin
         foreach (mq[i]) begin
            if (mq[i].tag == id && mq[i].ready) begin
               av = 1'b1;
               v  = mq[i].val;
            end
         end
      end
   endfunction

   // Per-cycle comparison against the model, then advance the model.
   always @(negedge clk_in) begin : cmp
      bit          hrdy, com, mis, acc, av;
      logic [31:0] v, e_id, e_val, e_pc;
      m_ent_t      e, t;
      if (!rst_in) begin
         chk("rst_issue_tag", 32'(issue_tag), 32'd0);
         chk("rst_rob_full", 32'(rob_full), 32'd0);
         chk("rst_set_dep_id", 32'(set_dep_id), 32'd0);
         chk("rst_set_dep_Q", 32'(set_dep_Q), 32'd0);
         chk("rst_avail_1", 32'(rob_avail_1), 32'd0);
         chk("rst_val_1", rob_val_1, 32'd0);
         chk("rst_avail_2", 32'(rob_avail_2), 32'd0);
         chk("rst_val_2", rob_val_2, 32'd0);
         chk("rst_set_id", 32'(set_id), 32'd0);
         chk("rst_set_val", set_val, 32'd0);
         chk("rst_rob_clear", 32'(rob_clear), 32'd0);
         chk("rst_redirect_pc", redirect_pc, 32'd0);
         mq.delete();
         m_tail = 0;
      end else begin
         hrdy = 1'b0;
         if (mq.size() > 0) hrdy = mq[0].ready;
         com   = rdy_in && hrdy;
         mis   = 1'b0;
         e_id  = 32'd0;
         e_val = 32'd0;
         e_pc  = 32'd0;
         if (com) begin
            mis = mq[0].is_br && (mq[0].taken != mq[0].pred);
            if (!mq[0].is_br) begin
               e_id  = 32'(mq[0].rd);
               e_val = mq[0].val;
            end
            if (mis) e_pc = mq[0].alt;
         end
         acc = rdy_in && issue_valid && (mq.size() < ROB_SIZE) && !mis;

         chk("issue_tag", 32'(issue_tag), 32'(m_tail));
         chk("rob_full", 32'(rob_full), 32'(mq.size() == ROB_SIZE));
         chk("set_dep_id", 32'(set_dep_id), acc ? 32'(issue_rd) : 32'd0);
         if (acc) chk("set_dep_Q", 32'(set_dep_Q), 32'(m_tail));
         chk("set_id", 32'(set_id), e_id);
         chk("set_val", set_val, e_val);
         chk("rob_clear", 32'(rob_clear), 32'(mis));
         chk("redirect_pc", redirect_pc, e_pc);
         qmodel(int'(get_rob_id_1), av, v);
         chk("rob_avail_1", 32'(rob_avail_1), 32'(av));
         if (av) chk("rob_val_1", rob_val_1, v);
         qmodel(int'(get_rob_id_2), av, v);
         chk("rob_avail_2", 32'(rob_avail_2), 32'(av));
         if (av) chk("rob_val_2", rob_val_2, v);

         if (rdy_in) begin
            if (mis) begin
               mq.delete();
               m_tail = 0;
            end else begin
               if (wb_valid) begin
                  foreach (mq[i]) begin
                     if (mq[i].tag == int'(wb_tag)) begin
                        t       = mq[i];
                        t.ready = 1'b1;
                        t.val   = wb_val;
                        t.taken = wb_taken;
                        mq[i]   = t;
                     end
                  end
               end
               if (com) void'(mq.pop_front());
               if (acc) begin
                  e.tag   = m_tail;
                  e.rd    = issue_rd;
                  e.is_br = issue_is_br;
                  e.pred  = issue_pred_taken;
                  e.ready = 1'b0;
                  e.taken = 1'b0;
                  e.alt   = issue_alt_pc;
                  e.val   = 32'd0;
                  mq.push_back(e);
                  m_tail = (m_tail + 1) % ROB_SIZE;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      issue_valid      = 1'b0;
      issue_rd         = 5'd0;
      issue_is_br      = 1'b0;
      issue_pred_taken = 1'b0;
      issue_alt_pc     = 32'd0;
      wb_valid         = 1'b0;
      wb_tag           = '0;
      wb_val           = 32'd0;
      wb_taken         = 1'b0;
   endtask

   task automatic iss(input int rd, input bit br, input bit pred, input logic [31:0] alt);
      issue_valid      = 1'b1;
      issue_rd         = 5'(rd);
      issue_is_br      = br;
      issue_pred_taken = pred;
      issue_alt_pc     = alt;
   endtask

   task automatic wb(input int tag, input logic [31:0] v, input bit tk);
      wb_valid = 1'b1;
      wb_tag   = 3'(tag);
      wb_val   = v;
      wb_taken = tk;
   endtask

   initial begin
      rst_in       = 1'b0;
      rdy_in       = 1'b1;
      get_rob_id_1 = '0;
      get_rob_id_2 = '0;
      idle();
      // Activity during reset must not reach the outputs.
      iss(7, 0, 0, 32'd0);
      wb(0, 32'hDEAD, 0);
      cyc(); settle();
      chk("lit_rst_dep_id", 32'(set_dep_id), 32'd0);
      chk("lit_rst_avail1", 32'(rob_avail_1), 32'd0);
      chk("lit_rst_val1", rob_val_1, 32'd0);
      cyc();
      rst_in = 1'b1;
      idle();
      cyc();

      // Single issue, writeback, commit.
      idle(); iss(5, 0, 0, 32'd0); settle();
      chk("lit_s1_dep_id", 32'(set_dep_id), 32'd5);
      chk("lit_s1_dep_Q", 32'(set_dep_Q), 32'd0);
      chk("lit_s1_issue_tag", 32'(issue_tag), 32'd0);
      cyc();
      idle(); wb(0, 32'h1234, 0); cyc();
      idle(); settle();
      chk("lit_s1_set_id", 32'(set_id), 32'd5);
      chk("lit_s1_set_val", set_val, 32'h1234);
      cyc();
      idle(); settle();
      chk("lit_s1_full", 32'(rob_full), 32'd0);
      chk("lit_s1_tail", 32'(issue_tag), 32'd1);
      chk("lit_s1_no_commit", 32'(set_id), 32'd0);
      cyc();

      // Fill to capacity, reject the ninth, free one slot.
      for (int i = 1; i <= 8; i++) begin
         idle(); iss(i, 0, 0, 32'd0); settle();
         chk("lit_fill_tag", 32'(issue_tag), 32'(i % 8));
         cyc();
      end
      idle(); iss(9, 0, 0, 32'd0); settle();
      chk("lit_full", 32'(rob_full), 32'd1);
      chk("lit_full_dep_id", 32'(set_dep_id), 32'd0);
      chk("lit_full_tag", 32'(issue_tag), 32'd1);
      cyc();
      idle(); iss(9, 0, 0, 32'd0); wb(1, 32'h11, 0); settle();
      chk("lit_full_wb_dep_id", 32'(set_dep_id), 32'd0);
      cyc();
      idle(); iss(9, 0, 0, 32'd0); settle();
      chk("lit_full_commit_id", 32'(set_id), 32'd1);
      chk("lit_full_commit_val", set_val, 32'h11);
      chk("lit_full_commit_full", 32'(rob_full), 32'd1);
      chk("lit_full_commit_dep", 32'(set_dep_id), 32'd0);
      cyc();
      idle(); settle();
      chk("lit_unfull", 32'(rob_full), 32'd0);
      chk("lit_unfull_tag", 32'(issue_tag), 32'd1);
      cyc();

      // Out-of-order writebacks, in-order commits (head is tag 2).
      idle(); wb(4, 32'hC, 0); cyc();
      idle(); wb(3, 32'hB, 0); cyc();
      idle(); wb(2, 32'hA, 0); cyc();
      idle(); settle();
      chk("lit_ooo_id0", 32'(set_id), 32'd2);
      chk("lit_ooo_val0", set_val, 32'hA);
      cyc();
      idle(); settle();
      chk("lit_ooo_id1", 32'(set_id), 32'd3);
      chk("lit_ooo_val1", set_val, 32'hB);
      cyc();
      idle(); settle();
      chk("lit_ooo_id2", 32'(set_id), 32'd4);
      chk("lit_ooo_val2", set_val, 32'hC);
      cyc();

      // Same-cycle writeback bypass on the query port.
      idle(); wb(6, 32'hBEEF, 0); get_rob_id_1 = 3'd6; get_rob_id_2 = 3'd7; settle();
      chk("lit_byp_avail1", 32'(rob_avail_1), 32'd1);
      chk("lit_byp_val1", rob_val_1, 32'hBEEF);
      chk("lit_byp_avail2", 32'(rob_avail_2), 32'd0);
      cyc();
      idle(); settle();
      chk("lit_stored_avail1", 32'(rob_avail_1), 32'd1);
      chk("lit_stored_val1", rob_val_1, 32'hBEEF);
      cyc();
      get_rob_id_1 = '0; get_rob_id_2 = '0;

      // Drain tags 5,6,7,0.
      idle(); wb(5, 32'h55, 0); cyc();
      idle(); wb(7, 32'h77, 0); settle();
      chk("lit_drain_id5", 32'(set_id), 32'd5);
      cyc();
      idle(); wb(0, 32'h80, 0); settle();
      chk("lit_drain_val6", set_val, 32'hBEEF);
      cyc();
      idle(); cyc();
      idle(); settle();
      chk("lit_drain_id8", 32'(set_id), 32'd8);
      chk("lit_drain_val8", set_val, 32'h80);
      cyc();
      idle(); cyc();

      // Mispredicted branch at head flushes younger entries and a concurrent issue.
      idle(); iss(9, 1, 0, 32'h1000); settle();
      chk("lit_br_tag", 32'(issue_tag), 32'd1);
      cyc();
      idle(); iss(10, 0, 0, 32'd0); cyc();
      idle(); iss(11, 0, 0, 32'd0); cyc();
      idle(); wb(1, 32'd0, 1); cyc();
      idle(); iss(12, 0, 0, 32'd0); wb(2, 32'h22, 0); settle();
      chk("lit_flush_clear", 32'(rob_clear), 32'd1);
      chk("lit_flush_pc", redirect_pc, 32'h1000);
      chk("lit_flush_dep_id", 32'(set_dep_id), 32'd0);
      chk("lit_flush_set_id", 32'(set_id), 32'd0);
      cyc();
      idle(); get_rob_id_1 = 3'd2; settle();
      chk("lit_post_clear", 32'(rob_clear), 32'd0);
      chk("lit_post_pc", redirect_pc, 32'd0);
      chk("lit_post_full", 32'(rob_full), 32'd0);
      chk("lit_post_tag", 32'(issue_tag), 32'd0);
      chk("lit_post_set_id", 32'(set_id), 32'd0);
      chk("lit_post_avail1", 32'(rob_avail_1), 32'd0);
      cyc();
      get_rob_id_1 = '0;
      idle(); cyc();

      // Twelve issue/commit pairs wrap both pointers.
      for (int i = 0; i < 12; i++) begin
         idle(); iss(i + 1, 0, 0, 32'd0); settle();
         chk("lit_wrap_tag", 32'(issue_tag), 32'(i % 8));
         cyc();
         idle(); wb(i % 8, 32'h100 + 32'(i), 0); cyc();
         idle(); settle();
         chk("lit_wrap_id", 32'(set_id), 32'(i + 1));
         chk("lit_wrap_val", set_val, 32'h100 + 32'(i));
         cyc();
      end

      // Correctly predicted branch retires silently.
      idle(); iss(9, 1, 1, 32'h2000); settle();
      chk("lit_okbr_tag", 32'(issue_tag), 32'd4);
      cyc();
      idle(); wb(4, 32'h99, 1); cyc();
      idle(); settle();
      chk("lit_okbr_clear", 32'(rob_clear), 32'd0);
      chk("lit_okbr_set_id", 32'(set_id), 32'd0);
      chk("lit_okbr_pc", redirect_pc, 32'd0);
      cyc();
      idle(); settle();
      chk("lit_okbr_next_tag", 32'(issue_tag), 32'd5);
      cyc();

      // rdy_in low freezes state and masks commit/rename.
      idle(); iss(3, 0, 0, 32'd0); cyc();
      idle(); wb(5, 32'h33, 0); cyc();
      rdy_in = 1'b0;
      idle(); iss(4, 0, 0, 32'd0); settle();
      chk("lit_stall_set_id", 32'(set_id), 32'd0);
      chk("lit_stall_dep_id", 32'(set_dep_id), 32'd0);
      chk("lit_stall_clear", 32'(rob_clear), 32'd0);
      cyc();
      idle(); iss(4, 0, 0, 32'd0); cyc();
      rdy_in = 1'b1;
      idle(); settle();
      chk("lit_resume_id", 32'(set_id), 32'd3);
      chk("lit_resume_val", set_val, 32'h33);
      chk("lit_resume_tag", 32'(issue_tag), 32'd6);
      cyc();

      // Asynchronous reset mid-stream.
      idle(); iss(6, 0, 0, 32'd0); cyc();
      idle(); iss(7, 0, 0, 32'd0); wb(6, 32'h66, 0); cyc();
      rst_in = 1'b0;
      idle(); iss(1, 0, 0, 32'd0); get_rob_id_1 = 3'd6; settle();
      chk("lit_arst_set_id", 32'(set_id), 32'd0);
      chk("lit_arst_tag", 32'(issue_tag), 32'd0);
      chk("lit_arst_avail1", 32'(rob_avail_1), 32'd0);
      chk("lit_arst_dep_id", 32'(set_dep_id), 32'd0);
      cyc();
      rst_in = 1'b1;
      idle(); settle();
      chk("lit_rel_tag", 32'(issue_tag), 32'd0);
      chk("lit_rel_full", 32'(rob_full), 32'd0);
      chk("lit_rel_avail1", 32'(rob_avail_1), 32'd0);
      chk("lit_rel_set_id", 32'(set_id), 32'd0);
      cyc();
      idle(); iss(2, 0, 0, 32'd0); settle();
      chk("lit_rel_dep_id", 32'(set_dep_id), 32'd2);
      chk("lit_rel_dep_Q", 32'(set_dep_Q), 32'd0);
      cyc();
      idle(); cyc();
      idle(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer: the ROB end of the register-file rename/commit interface.
- Allocates entries in program order at issue and drives rename tags (set_dep_id/set_dep_Q) into the register file.
- Captures results from writeback and answers register-file operand queries (get_rob_id_k -> rob_avail_k/rob_val_k).
- Retires in order through set_id/set_val, and flushes the machine on branch mispredict (rob_clear).

Parameters:
- ROB_BIT, 3, entry index width; must match `ROB_R in const.v.
- ROB_SIZE, 8, entry count; equals 2**ROB_BIT.

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; low freezes all state
- issue_valid  input  1  issue request
- issue_rd  input  5  destination register; 0 = no write
- issue_is_br  input  1  entry is a conditional branch
- issue_pred_taken  input  1  predicted direction
- issue_alt_pc  input  32  redirect PC if the prediction is wrong
- issue_tag  output  ROB_BIT  index allocated on this issue (tail)
- rob_full  output  1  no free entry
- set_dep_id  output  5  rename destination; 0 = none
- set_dep_Q  output  ROB_BIT  rename tag
- wb_valid  input  1  writeback strobe
- wb_tag  input  ROB_BIT  entry written back
- wb_val  input  32  result value
- wb_taken  input  1  actual branch outcome
- get_rob_id_1  input  ROB_BIT  operand-1 query tag
- rob_avail_1  output  1  operand-1 value ready
- rob_val_1  output  32  operand-1 value
- get_rob_id_2  input  ROB_BIT  operand-2 query tag
- rob_avail_2  output  1  operand-2 value ready
- rob_val_2  output  32  operand-2 value
- set_id  output  5  commit destination; 0 = none
- set_val  output  32  commit value
- rob_clear  output  1  flush pulse
- redirect_pc  output  32  fetch redirect target, valid with rob_clear

Behaviour:
- State:
  - head, tail: ROB_BIT wrap-around pointers.
  - count: 0..ROB_SIZE.
  - Per entry: busy, ready, rd, is_br, pred_taken, taken, alt_pc, val.
- Reset (rst_in=0, async):
  - head=tail=count=0, all busy=0, all ready=0.
  - All outputs 0 while in reset.
- rdy_in=0:
  - No state update.
  - set_id, set_dep_id, rob_clear forced to 0.
- rob_full = (count==ROB_SIZE); combinational from registered count.
- Issue:
  - Accepted when issue_valid && !rob_full && rdy_in && !rob_clear.
  - On the accepting edge: entry[tail] gets busy=1, ready=0 and the issue fields; tail+1 wraps mod ROB_SIZE.
  - issue_tag = tail, combinational.
  - set_dep_id = issue_rd and set_dep_Q = tail, combinational in the accepting cycle; otherwise set_dep_id=0.
- Writeback:
  - On the edge: if wb_valid && busy[wb_tag], set ready=1, val=wb_val, taken=wb_taken.
  - Writeback to a non-busy entry is ignored.
- Query (combinational, k=1,2):
  - rob_avail_k = (busy && ready)[get_rob_id_k] || (wb_valid && wb_tag==get_rob_id_k).
  - rob_val_k = wb_val on a writeback tag match, else val[get_rob_id_k].
  - Same-cycle writeback bypass is mandatory.
- Commit:
  - At most one per cycle, when busy[head] && ready[head]; combinational outputs, entry pops on that edge.
  - Non-branch: set_id = rd[head], set_val = val[head]; the register file writes on the same edge.
  - Branch with taken==pred_taken: pops; set_id=0.
  - Branch with taken!=pred_taken:
    - rob_clear=1 and redirect_pc = alt_pc[head] in that cycle; set_id=0.
    - On the edge all busy cleared and head=tail=count=0.
    - Any issue that cycle is rejected and set_dep_id=0.
  - Otherwise set_id=0, rob_clear=0, set_val=0, redirect_pc=0.
- Latency: a writeback at edge N makes the head committable in cycle N+1. Writeback and commit of the head never occur in the same cycle.
- Count update: issue and commit on the same edge leave count unchanged. Full plus commit still rejects issue that cycle, since full is registered.
- A writeback on the flush edge is discarded.

Test Plan:
- Reset, then issue rd=5 -> set_dep_id=5, set_dep_Q=0, issue_tag=0. Writeback tag0 val=0x1234 -> next cycle set_id=5, set_val=0x1234, count back to 0.
- Issue 8 entries (rd=1..8) with no writeback -> rob_full=1 after 8th edge; 9th issue_valid gives set_dep_id=0 and tail unchanged. Writeback+commit entry0 -> rob_full drops next cycle.
- Writebacks out of order to tags 2,1,0 (vals 0xC,0xB,0xA) -> commits in order: set_id=rd0 (0xA), rd1 (0xB), rd2 (0xC) on three consecutive cycles.
- wb_valid tag=3 val=0xBEEF with get_rob_id_1=3 in the same cycle -> rob_avail_1=1, rob_val_1=0xBEEF combinationally.
- Branch at head, pred_taken=0, writeback taken=1, alt_pc=0x1000, two younger entries plus a concurrent issue -> rob_clear=1, redirect_pc=0x1000 for one cycle; next cycle count=0, rob_full=0, no commits.
- Wrap: 12 issue/commit pairs -> tail and head wrap 7->0 and issue_tag sequence 0..7,0..3. Assert rst_in low mid-stream -> outputs 0 immediately, empty after release.
